solution_reporter: RTL and testbench

- Result-side transmitter for the miner core; the opposite end of the load path.
- When the solver claims a solution (sol_claim), the block latches the candidate nonce and serializes a framed result to the host on a single wire.
- It then waits for the host's verdict and converts it into the controller's return signals: sol_verified (accepted, go IDLE) or unhalt (rejected or timed out, resume SOLVE).

---
 rtl/solution_reporter.sv | 178 +++++++++++++++++
 tb/tb_solution_reporter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/solution_reporter.sv
// solution_reporter
//   Result-side transmitter for the miner core. When the solver claims a
//   solution, the candidate nonce is latched into a frame and sent to the
//   host on a single serial wire. The block then waits for the host's
//   verdict and returns it to the controller as sol_verified (accepted) or
//   unhalt (rejected or timed out).
//
//   Frame, first bit on the wire first:
//     start(0), SYNC_BYTE LSB first, nonce LSB first, parity(^nonce), stop(1)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   sol_claim     solver reports a candidate (sampled in IDLE only)
//   nonce         candidate nonce, valid together with sol_claim
//   rx_ack        host accepted (sampled in WAIT_ACK only)
//   rx_nack       host rejected (sampled in WAIT_ACK only, wins over rx_ack)
//   tx_serial     serial result line, idles high
//   tx_busy       high whenever the block is not in IDLE
//   sol_verified  one-cycle pulse on accept
//   unhalt        one-cycle pulse on reject or timeout
//   reject_count  saturating count of rejects plus timeouts
//   state_dbg     current FSM state (0 IDLE, 1 SEND, 2 WAIT_ACK)
//
// Handshake: sol_claim is a single-cycle request with no ready; it is
// taken only when state_dbg reads IDLE and dropped otherwise. The verdict
// pulses go high in the same cycle tx_busy falls, so the controller can use
// either as its completion indication.
module solution_reporter #(
  parameter int          NONCE_W      = 32,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          ACK_TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sol_claim,
  input  logic [NONCE_W-1:0] nonce,
  input  logic               rx_ack,
  input  logic               rx_nack,
  output logic               tx_serial,
  output logic               tx_busy,
  output logic               sol_verified,
  output logic               unhalt,
  output logic [7:0]         reject_count,
  output logic [1:0]         state_dbg
);

  localparam int FRAME_BITS = NONCE_W + 11;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  // Degenerate parameter values (1) still need a one-bit counter.
  localparam int CYC_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W       = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t                  state_q, state_n;
  logic [FRAME_BITS-1:0]   frame_q, frame_n;
  logic [BIT_W-1:0]        bit_q, bit_n, bit_inc;
  logic [CYC_W-1:0]        cyc_q, cyc_n;
  logic [TO_W-1:0]         to_q, to_n;
  logic                    tx_n, busy_n, ver_n, unh_n;
  logic [7:0]              cnt_n;
  logic                    reject;

  assign state_dbg = state_q;
  assign bit_inc   = bit_q + 1'b1;

  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    bit_n   = bit_q;
    cyc_n   = cyc_q;
    to_n    = to_q;
    tx_n    = tx_serial;
    busy_n  = tx_busy;
    ver_n   = 1'b0;
    unh_n   = 1'b0;
    cnt_n   = reject_count;
    reject  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (sol_claim) begin
          // Bit 0 is the start bit and goes out immediately.
          frame_n = {1'b1, ^nonce, nonce, SYNC_BYTE, 1'b0};
          state_n = ST_SEND;
          bit_n   = '0;
          cyc_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      ST_SEND: begin
        if (cyc_q == LAST_CYC) begin
          cyc_n = '0;
          if (bit_q == LAST_BIT) begin
            state_n = ST_WAIT_ACK;
            bit_n   = '0;
            to_n    = '0;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_inc;
            tx_n  = frame_q[bit_inc];
          end
        end else begin
          cyc_n = cyc_q + 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        tx_n = 1'b1;
        // A verdict arriving on the last timeout cycle still counts.
        if (rx_nack) begin
          reject = 1'b1;
        end else if (rx_ack) begin
          ver_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else if (to_q == LAST_TO) begin
          reject = 1'b1;
        end else begin
          to_n = to_q + 1'b1;
        end
        if (reject) begin
          unh_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
          if (reject_count != 8'hFF) cnt_n = reject_count + 8'd1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      bit_q        <= '0;
      cyc_q        <= '0;
      to_q         <= '0;
      tx_serial    <= 1'b1;
      tx_busy      <= 1'b0;
      sol_verified <= 1'b0;
      unhalt       <= 1'b0;
      reject_count <= 8'd0;
    end else begin
      state_q      <= state_n;
      frame_q      <= frame_n;
      bit_q        <= bit_n;
      cyc_q        <= cyc_n;
      to_q         <= to_n;
      tx_serial    <= tx_n;
      tx_busy      <= busy_n;
      sol_verified <= ver_n;
      unhalt       <= unh_n;
      reject_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_solution_reporter.sv
// Testbench for solution_reporter: directed frames with hand-computed
// contents, verdict handling, timeout and saturation, ignored inputs and
// reset mid-frame. Expected frames and verdicts are queued by the stimulus
// process and consumed by a free-running monitor.
module tb_solution_reporter;

  localparam int NW  = 32;
  localparam int CPB = 4;
  localparam int ATO = 16;
  localparam int FB  = NW + 11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Frames as {stop, parity, nonce, sync, start}, worked out by hand.
  localparam logic [FB-1:0] FR_ONE  = 43'h600_0000_034A; // nonce 0000_0001, parity 1
  localparam logic [FB-1:0] FR_ALL1 = 43'h5FF_FFFF_FF4A; // nonce FFFF_FFFF, parity 0
  localparam logic [FB-1:0] FR_1234 = 43'h624_68AC_F14A; // nonce 1234_5678, parity 1

  logic          clk = 1'b0;
  logic          rst;
  logic          sol_claim;
  logic [NW-1:0] nonce;
  logic          rx_ack;
  logic          rx_nack;
  logic          tx_serial;
  logic          tx_busy;
  logic          sol_verified;
  logic          unhalt;
  logic [7:0]    reject_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected verdicts {sol_verified, unhalt, reject_count} and frames.
  logic [9:0]    exp_q[$];
  logic [FB-1:0] exp_frame_q[$];

  solution_reporter #(
    .NONCE_W     (NW),
    .SYNC_BYTE   (8'hA5),
    .CLKS_PER_BIT(CPB),
    .ACK_TIMEOUT (ATO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sol_claim   (sol_claim),
    .nonce       (nonce),
    .rx_ack      (rx_ack),
    .rx_nack     (rx_nack),
    .tx_serial   (tx_serial),
    .tx_busy     (tx_busy),
    .sol_verified(sol_verified),
    .unhalt      (unhalt),
    .reject_count(reject_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          pulse_prev = 1'b0;
  logic          rx_active  = 1'b0;
  int            rx_cnt     = 0;
  logic [FB-1:0] rx_bits    = '0;
  logic          glitch     = 1'b0;

  always @(negedge clk) begin
    logic [9:0]    e;
    logic [FB-1:0] ef;
    if (rst) begin
      rx_active  = 1'b0;
      pulse_prev = 1'b0;
    end else begin
      // Verdict pulses
      if (sol_verified || unhalt) begin
        if (pulse_prev) check("pulse_width", 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {sol_verified, unhalt, reject_count}, 10'h0);
        end else begin
          e = exp_q.pop_front();
          check("verdict", {sol_verified, unhalt, reject_count}, e);
          check("busy_at_pulse", tx_busy, 0);
        end
      end
      pulse_prev = sol_verified | unhalt;

      if (state_dbg != S_SEND && tx_serial !== 1'b1) check("line_idle_high", tx_serial, 1);

      // Frame capture: one bit per CPB cycles, every cycle of a bit must match.
      if (!rx_active && state_dbg == S_SEND) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_bits   = '0;
        glitch    = 1'b0;
      end
      if (rx_active) begin
        if (state_dbg == S_IDLE) begin
          rx_active = 1'b0;
        end else if (state_dbg == S_WAIT) begin
          check("send_cycles", rx_cnt, FB * CPB);
          check("bit_hold", glitch, 0);
          if (exp_frame_q.size() == 0) begin
            check("unexpected_frame", rx_bits, 0);
          end else begin
            ef = exp_frame_q.pop_front();
            check("frame", rx_bits, ef);
          end
          rx_active = 1'b0;
        end else begin
          if (rx_cnt >= FB * CPB) glitch = 1'b1;
          else if (rx_cnt % CPB == 0) rx_bits[rx_cnt / CPB] = tx_serial;
          else if (tx_serial !== rx_bits[rx_cnt / CPB]) glitch = 1'b1;
          rx_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic claim(input logic [NW-1:0] n, input logic [FB-1:0] fr, input bit push);
    sol_claim = 1'b1;
    nonce     = n;
    if (push) exp_frame_q.push_back(fr);
    @(posedge clk);
    #1;
    check("busy_rise", tx_busy, 1);
    check("start_bit", tx_serial, 0);
    sol_claim = 1'b0;
    nonce     = NW'($urandom_range(0, 32'hFFFF_FFFF));
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int n = 0;
    @(negedge clk);
    while (state_dbg !== s && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, state_dbg, s);
  endtask

  task automatic pulse_in(input logic a, input logic k);
    rx_ack  = a;
    rx_nack = k;
    @(negedge clk);
    rx_ack  = 1'b0;
    rx_nack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [7:0] cnt;
    rst       = 1'b1;
    sol_claim = 1'b0;
    nonce     = '0;
    rx_ack    = 1'b0;
    rx_nack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_verified", sol_verified, 0);
    check("rst_unhalt", unhalt, 0);
    check("rst_count", reject_count, 0);
    check("rst_state", state_dbg, S_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame, then accept five cycles into WAIT_ACK.
    claim(32'h0000_0001, FR_ONE, 1'b1);
    wait_state(S_WAIT, "enter_wait_1");
    repeat (5) @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 8'd0});
    pulse_in(1'b1, 1'b0);
    wait_state(S_IDLE, "idle_after_ack");

    // Reject with ack and nack together.
    claim(32'hFFFF_FFFF, FR_ALL1, 1'b1);
    wait_state(S_WAIT, "enter_wait_2");
    exp_q.push_back({1'b0, 1'b1, 8'd1});
    pulse_in(1'b1, 1'b1);
    wait_state(S_IDLE, "idle_after_nack");

    // Claim and ack mid-SEND are ignored; original nonce goes out.
    claim(32'h0000_0001, FR_ONE, 1'b1);
    repeat (40) @(negedge clk);
    sol_claim = 1'b1;
    nonce     = 32'h1234_5678;
    rx_ack    = 1'b1;
    @(negedge clk);
    sol_claim = 1'b0;
    rx_ack    = 1'b0;
    wait_state(S_WAIT, "enter_wait_3");
    check("busy_in_wait", tx_busy, 1);
    exp_q.push_back({1'b0, 1'b1, 8'd2});
    pulse_in(1'b0, 1'b1);
    wait_state(S_IDLE, "idle_after_nack2");

    // Timeout: unhalt 16 cycles after entering WAIT_ACK.
    claim(32'h0000_0001, FR_ONE, 1'b1);
    wait_state(S_WAIT, "enter_wait_4");
    exp_q.push_back({1'b0, 1'b1, 8'd3});
    k = 0;
    while (!unhalt && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, ATO);

    // 300 back-to-back timeouts; count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      cnt = (4 + i > 255) ? 8'd255 : 8'(4 + i);
      exp_q.push_back({1'b0, 1'b1, cnt});
      claim(32'h0000_0001, FR_ONE, 1'b1);
      wait_state(S_IDLE, "idle_after_timeout");
    end
    check("count_saturated", reject_count, 255);

    // Reset during bit 20 of a frame.
    @(negedge clk);
    claim(32'hFFFF_FFFF, FR_ALL1, 1'b0);
    repeat (81) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx_serial", tx_serial, 1);
    check("midrst_tx_busy", tx_busy, 0);
    check("midrst_verified", sol_verified, 0);
    check("midrst_unhalt", unhalt, 0);
    check("midrst_count", reject_count, 0);
    rst = 1'b0;
    @(negedge clk);
    claim(32'h1234_5678, FR_1234, 1'b1);
    wait_state(S_WAIT, "enter_wait_5");
    exp_q.push_back({1'b0, 1'b1, 8'd1});
    pulse_in(1'b0, 1'b1);
    wait_state(S_IDLE, "idle_final");

    repeat (5) @(negedge clk);
    check("verdicts_drained", exp_q.size(), 0);
    check("frames_drained", exp_frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
